// File: rtl/wb_regfile_scoreboard_if.sv
// Writeback / decode bundle for the register file with pending-write scoreboard.
//   master : pipeline side. Drives writeback (wb_*), read addresses (rs*_addr),
//            issue (iss_*) and flush. Samples read data, iss_ready, stall, err_uflow.
//   slave  : register file side. It is the opposite direction of every signal.
interface wb_regfile_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            iss_valid;
  logic            iss_we;
  logic [AW-1:0]   iss_rd;
  logic            iss_ready;
  logic            stall;
  logic            flush;
  logic            err_uflow;

  modport master (
    output wb_we, wb_rd, wb_data, rs1_addr, rs2_addr,
           iss_valid, iss_we, iss_rd, flush,
    input  rs1_data, rs2_data, iss_ready, stall, err_uflow
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, rs1_addr, rs2_addr,
           iss_valid, iss_we, iss_rd, flush,
    output rs1_data, rs2_data, iss_ready, stall, err_uflow
  );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// Integer register file plus a per-register pending-write scoreboard.
// Writebacks update the file at the clock edge. Both read ports are
// combinational and forward a same-cycle writeback. A small counter per
// register tracks the writers that decode has issued and that have not yet
// written back. Decode stalls while a source register is still pending.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset. It clears registers, counters and err_uflow.
//   bus  : slave side of wb_regfile_scoreboard_if. It carries the writeback, read,
//          issue and flush signals. Its outputs are rs1/rs2_data, iss_ready, stall
//          and err_uflow.
module wb_regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int PEND_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  wb_regfile_scoreboard_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] CNT_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

  // Local copies of the interface inputs keep the logic below readable.
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            iss_valid;
  logic            iss_we;
  logic [AW-1:0]   iss_rd;
  logic            flush;

  assign wb_we     = bus.wb_we;
  assign wb_rd     = bus.wb_rd;
  assign wb_data   = bus.wb_data;
  assign rs1_addr  = bus.rs1_addr;
  assign rs2_addr  = bus.rs2_addr;
  assign iss_valid = bus.iss_valid;
  assign iss_we    = bus.iss_we;
  assign iss_rd    = bus.iss_rd;
  assign flush     = bus.flush;

  logic [XLEN-1:0]   regs_q [NREG];
  logic [PEND_W-1:0] cnt_q  [NREG];
  logic [NREG-1:0]   uflow;
  logic              iss_ready;
  logic              iss_fire;
  logic [PEND_W-1:0] iss_cnt;
  logic              err_uflow_reg;

  // A saturated destination can still accept an issue when a writeback
  // retires one of its writers in the same cycle.
  assign iss_cnt   = cnt_q[iss_rd];
  assign iss_ready = !(iss_we && (iss_rd != '0) && (iss_cnt == CNT_MAX)
                       && !(wb_we && (wb_rd == iss_rd)));
  assign iss_fire  = iss_valid && iss_we && iss_ready;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    if (gi == 0) begin : g_x0
      assign regs_q[gi] = '0;
      assign cnt_q[gi]  = '0;
      assign uflow[gi]  = 1'b0;
    end else begin : g_xn
      logic [XLEN-1:0]   data_reg;
      logic [PEND_W-1:0] cnt_reg;
      logic [PEND_W-1:0] cnt_next;
      logic              uflow_next;
      logic              inc;
      logic              dec;

      assign inc = iss_fire && (iss_rd == AW'(gi));
      assign dec = wb_we && (wb_rd == AW'(gi));

      // An issue and a writeback in the same cycle cancel out. This holds
      // even from zero, because the writer completes in the cycle it issues.
      always_comb begin
        cnt_next   = cnt_reg;
        uflow_next = 1'b0;
        if (flush) begin
          cnt_next = '0;
        end else if (inc && !dec) begin
          cnt_next = cnt_reg + CNT_ONE;
        end else if (dec && !inc) begin
          if (cnt_reg == '0) uflow_next = 1'b1;
          else               cnt_next   = cnt_reg - CNT_ONE;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg <= '0;
          cnt_reg  <= '0;
        end else begin
          if (dec) data_reg <= wb_data;
          cnt_reg <= cnt_next;
        end
      end

      assign regs_q[gi] = data_reg;
      assign cnt_q[gi]  = cnt_reg;
      assign uflow[gi]  = uflow_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_uflow_reg <= 1'b0;
    else if (|uflow) err_uflow_reg <= 1'b1;
  end

  // A register stops being busy in the cycle its last pending writer
  // writes back, because the read port forwards that data.
  logic [PEND_W-1:0] cnt_rs1;
  logic [PEND_W-1:0] cnt_rs2;
  logic              busy_rs1;
  logic              busy_rs2;

  assign cnt_rs1  = cnt_q[rs1_addr];
  assign cnt_rs2  = cnt_q[rs2_addr];
  assign busy_rs1 = (rs1_addr != '0) && (cnt_rs1 != '0)
                    && !(wb_we && (wb_rd == rs1_addr) && (cnt_rs1 == CNT_ONE));
  assign busy_rs2 = (rs2_addr != '0) && (cnt_rs2 != '0)
                    && !(wb_we && (wb_rd == rs2_addr) && (cnt_rs2 == CNT_ONE));

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  always_comb begin
    rs1_val = regs_q[rs1_addr];
    if (rs1_addr == '0)                       rs1_val = '0;
    else if (wb_we && (wb_rd == rs1_addr))    rs1_val = wb_data;
  end

  always_comb begin
    rs2_val = regs_q[rs2_addr];
    if (rs2_addr == '0)                       rs2_val = '0;
    else if (wb_we && (wb_rd == rs2_addr))    rs2_val = wb_data;
  end

  assign bus.rs1_data  = rs1_val;
  assign bus.rs2_data  = rs2_val;
  assign bus.iss_ready = iss_ready;
  assign bus.stall     = busy_rs1 || busy_rs2;
  assign bus.err_uflow = err_uflow_reg;
endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
module tb_wb_regfile_scoreboard;
  localparam int MAXC = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_regfile_scoreboard_if bus ();

  wb_regfile_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  // Reference state: register values, in-flight writer counts, sticky error.
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic idle();
    bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.rs1_addr = '0; bus.rs2_addr = '0;
    bus.iss_valid = 1'b0; bus.iss_we = 1'b0; bus.iss_rd = '0;
    bus.flush = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input int a);
    if (a == 0) return 32'h0;
    if (bus.wb_we && int'(bus.wb_rd) == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input int a);
    bit retiring;
    retiring = bus.wb_we && int'(bus.wb_rd) == a && m_cnt[a] == 1;
    return (a != 0) && (m_cnt[a] > 0) && !retiring;
  endfunction

  function automatic bit exp_ready();
    int r;
    r = int'(bus.iss_rd);
    return !(bus.iss_we && r != 0 && m_cnt[r] == MAXC
             && !(bus.wb_we && int'(bus.wb_rd) == r));
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".rs1"},   bus.rs1_data, exp_rd(int'(bus.rs1_addr)));
    chk({tag, ".rs2"},   bus.rs2_data, exp_rd(int'(bus.rs2_addr)));
    chk({tag, ".stall"}, 32'(bus.stall),
        32'(exp_busy(int'(bus.rs1_addr)) || exp_busy(int'(bus.rs2_addr))));
    chk({tag, ".ready"}, 32'(bus.iss_ready), 32'(exp_ready()));
    chk({tag, ".err"},   32'(bus.err_uflow), 32'(m_err));
  endtask

  // Called at a negedge with the inputs already driven. It checks the outputs,
  // clocks once, updates the model and returns at the next negedge.
  task automatic cycle(input string tag);
    bit fire;
    int n;
    #1;
    check_outputs(tag);
    $display("txn %0d %s wb=%b/x%0d/%h iss=%b%b/x%0d fl=%b rs=x%0d,x%0d",
             txn, tag, bus.wb_we, bus.wb_rd, bus.wb_data, bus.iss_valid, bus.iss_we,
             bus.iss_rd, bus.flush, bus.rs1_addr, bus.rs2_addr);
    txn++;
    fire = bus.iss_valid && bus.iss_we && exp_ready();
    @(posedge clk);
    if (bus.wb_we && bus.wb_rd != 0) m_regs[bus.wb_rd] = bus.wb_data;
    for (int r = 1; r < 32; r++) begin
      if (bus.flush) begin
        m_cnt[r] = 0;
      end else begin
        n = m_cnt[r];
        if (fire && int'(bus.iss_rd) == r) n = n + 1;
        if (bus.wb_we && int'(bus.wb_rd) == r) n = n - 1;
        if (n < 0) begin
          n = 0;
          m_err = 1'b1;
        end
        m_cnt[r] = n;
      end
    end
    @(negedge clk);
  endtask

  task automatic issue(input int rd);
    idle();
    bus.iss_valid = 1'b1; bus.iss_we = 1'b1; bus.iss_rd = 5'(rd);
  endtask

  task automatic wb(input int rd, input logic [31:0] d);
    idle();
    bus.wb_we = 1'b1; bus.wb_rd = 5'(rd); bus.wb_data = d;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();

    // 1: reset state on every address
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bus.rs1_addr = 5'(i);
      bus.rs2_addr = 5'(31 - i);
      #1;
      check_outputs("t1_reset");
    end
    @(negedge clk);
    rst = 1'b0;
    idle();

    // 2: write with bypass, hold, write to x0 is ignored
    wb(5, 32'hDEADBEEF); bus.rs1_addr = 5'd5;
    #1; chk("t2_bypass_lit", bus.rs1_data, 32'hDEADBEEF);
    cycle("t2_bypass");
    idle(); bus.rs1_addr = 5'd5;
    #1; chk("t2_hold_lit", bus.rs1_data, 32'hDEADBEEF);
    cycle("t2_hold");
    wb(0, 32'h1234); bus.rs1_addr = 5'd0;
    cycle("t2_x0_wr");
    idle(); bus.rs1_addr = 5'd0;
    #1; chk("t2_x0_lit", bus.rs1_data, 32'h0);
    cycle("t2_x0_rd");

    // 3: two writers to x7, stall until the last one writes back
    issue(7); cycle("t3_iss");
    issue(7); cycle("t3_iss");
    idle(); bus.rs2_addr = 5'd7;
    #1; chk("t3_stall_lit", 32'(bus.stall), 32'd1);
    cycle("t3_stall");
    wb(7, 32'hA1A1A1A1); bus.rs2_addr = 5'd7;
    #1; chk("t3_stall1_lit", 32'(bus.stall), 32'd1);
    cycle("t3_wb1");
    wb(7, 32'hB2B2B2B2); bus.rs2_addr = 5'd7;
    #1; chk("t3_release_lit", 32'(bus.stall), 32'd0);
    chk("t3_data_lit", bus.rs2_data, 32'hB2B2B2B2);
    cycle("t3_wb2");

    // 4: saturation of x3
    for (int k = 0; k < 3; k++) begin
      issue(3); cycle("t4_iss");
    end
    issue(3);
    #1; chk("t4_full_lit", 32'(bus.iss_ready), 32'd0);
    cycle("t4_full");
    issue(3); bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h33;
    #1; chk("t4_wbfree_lit", 32'(bus.iss_ready), 32'd1);
    cycle("t4_both");
    issue(3);
    #1; chk("t4_still3_lit", 32'(bus.iss_ready), 32'd0);
    cycle("t4_still3");
    for (int k = 0; k < 3; k++) begin
      wb(3, 32'(k + 16'h300)); cycle("t4_drain");
    end

    // 5: flush clears pending writers; a later writeback underflows
    issue(4); cycle("t5_iss");
    issue(9); cycle("t5_iss");
    idle(); bus.flush = 1'b1; bus.rs1_addr = 5'd4; bus.rs2_addr = 5'd9;
    bus.iss_valid = 1'b1; bus.iss_we = 1'b1; bus.iss_rd = 5'd4;
    cycle("t5_flush");
    idle(); bus.rs1_addr = 5'd4; bus.rs2_addr = 5'd9;
    #1; chk("t5_noStall_lit", 32'(bus.stall), 32'd0);
    cycle("t5_after");
    wb(4, 32'h44); cycle("t5_uflow");
    idle();
    #1; chk("t5_err_lit", 32'(bus.err_uflow), 32'd1);
    for (int k = 0; k < 3; k++) cycle("t5_sticky");

    // 6: asynchronous reset between edges
    issue(10); cycle("t6_iss");
    idle(); bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd10;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_rs1_lit", bus.rs1_data, 32'h0);
    chk("t6_stall_lit", 32'(bus.stall), 32'd0);
    chk("t6_err_lit", 32'(bus.err_uflow), 32'd0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    cycle("t6_after");

    // Random traffic concentrated on a few registers
    for (int k = 0; k < 600; k++) begin
      idle();
      bus.wb_we     = ($urandom_range(0, 2) == 0);
      bus.wb_rd     = 5'($urandom_range(0, 7));
      bus.wb_data   = $urandom;
      bus.rs1_addr  = 5'($urandom_range(0, 8));
      bus.rs2_addr  = 5'($urandom_range(0, 8));
      bus.iss_valid = ($urandom_range(0, 1) == 1);
      bus.iss_we    = ($urandom_range(0, 3) != 0);
      bus.iss_rd    = 5'($urandom_range(0, 7));
      bus.flush     = ($urandom_range(0, 40) == 0);
      if (k == 300) begin
        rst = 1'b1;
        #1;
        model_reset();
        #1;
        rst = 1'b0;
      end
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
